// File: rtl/u_seqdiv16by8_rst.sv
// u_seqdiv16by8_rst: restoring divider, one quotient bit per clock, valid/ready on both sides.
// Define U_SEQDIV_PRODUCT_CHECK_EN to add a q*b+r reconstruction check driving chk_err.
module u_seqdiv16by8_rst #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] a,
  input  logic [N-1:0]   b,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] q,
  output logic [N-1:0]   r,
  output logic           div0,
  output logic           chk_err
);
  localparam int CW = $clog2(2*N) + 1;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t         state_q, state_d;
  logic [N-1:0]   b_q, b_d;
  logic [N-1:0]   pr_q, pr_d;
  logic [2*N-1:0] qs_q, qs_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2*N-1:0] q_q, q_d;
  logic [N-1:0]   r_q, r_d;
  logic           div0_q, div0_d;
  logic [N:0]     t;
  logic           qbit;
  logic [N-1:0]   pr_n;
  logic [2*N-1:0] qs_n;
  logic           last;
  // The partial remainder always stays below b, so its N+1-th bit is only needed inside t.
  always_comb begin
    t    = {pr_q, qs_q[2*N-1]};
    qbit = t >= {1'b0, b_q};
    pr_n = qbit ? t[N-1:0] - b_q : t[N-1:0];
    qs_n = {qs_q[2*N-2:0], qbit};
    last = state_q == BUSY && cnt_q == CW'(2*N-1);
  end
  always_comb begin
    state_d = state_q;
    b_d     = b_q;
    pr_d    = pr_q;
    qs_d    = qs_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    div0_d  = div0_q;
    case (state_q)
      IDLE: if (in_valid) begin
        b_d     = b;
        pr_d    = '0;
        qs_d    = a;
        cnt_d   = '0;
        state_d = b == '0 ? DONE : BUSY;
        q_d     = b == '0 ? '1 : q_q;
        r_d     = b == '0 ? a[N-1:0] : r_q;
        div0_d  = b == '0 ? 1'b1 : div0_q;
      end
      BUSY: begin
        pr_d    = pr_n;
        qs_d    = qs_n;
        cnt_d   = cnt_q + CW'(1);
        state_d = last ? DONE : BUSY;
        q_d     = last ? qs_n : q_q;
        r_d     = last ? pr_n : r_q;
        div0_d  = last ? 1'b0 : div0_q;
      end
      DONE:    state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      b_q     <= '0;
      pr_q    <= '0;
      qs_q    <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      b_q     <= b_d;
      pr_q    <= pr_d;
      qs_q    <= qs_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
      div0_q  <= div0_d;
    end
  end
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign q         = q_q;
  assign r         = r_q;
  assign div0      = div0_q;
`ifdef U_SEQDIV_PRODUCT_CHECK_EN
  logic [2*N-1:0] a_q;
  logic           chk_q, chk_d;
  logic [3*N-1:0] recon;
  always_comb begin
    recon = {{N{1'b0}}, qs_n} * {{2*N{1'b0}}, b_q} + {{2*N{1'b0}}, pr_n};
    chk_d = state_q == IDLE ? 1'b0 :
            last ? (recon != {{N{1'b0}}, a_q}) || (pr_n >= b_q) :
            (state_q == DONE && out_ready) ? 1'b0 : chk_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q   <= '0;
      chk_q <= 1'b0;
    end else begin
      a_q   <= (state_q == IDLE && in_valid) ? a : a_q;
      chk_q <= chk_d;
    end
  end
  assign chk_err = chk_q;
`else
  assign chk_err = 1'b0;
`endif
endmodule
